// File: rtl/ring_scan_pkg.sv
// Shared types and constants for the ring-scanned four-digit hex display.
package ring_scan_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SCAN  = 2'd1,
    FAULT = 2'd2
  } state_t;

  // Segment patterns {g,f,e,d,c,b,a}, indexed by hex digit value (entry 15 first).
  localparam logic [15:0][6:0] SEG_TABLE = {
    7'h71, 7'h79, 7'h5E, 7'h39, 7'h7C, 7'h77, 7'h6F, 7'h7F,
    7'h07, 7'h7D, 7'h6D, 7'h66, 7'h4F, 7'h5B, 7'h06, 7'h3F
  };

  function automatic logic is_onehot(input logic [3:0] v);
    return (v != 4'd0) && ((v & (v - 4'd1)) == 4'd0);
  endfunction

  function automatic logic [3:0] rotl4(input logic [3:0] v);
    return {v[2:0], v[3]};
  endfunction

endpackage

// File: rtl/ring_scan_display_hex_to_seg7.sv
// Combinational hex digit to seven-segment decoder.
module hex_to_seg7
  import ring_scan_pkg::*;
(
  input  logic [3:0] hex,
  output logic [6:0] seg
);

  assign seg = SEG_TABLE[hex];

endmodule

// File: rtl/ring_scan_display.sv
// Drives a four-digit display from an external one-hot ring counter, counts
// rotations and traps illegal ring phases or steps.
module ring_scan_display
  import ring_scan_pkg::*;
#(
  parameter int ROT_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [3:0]       ring_q,
  input  logic             load_valid,
  input  logic [15:0]      load_data,
  output logic             load_ready,
  output logic [3:0]       an,
  output logic [6:0]       seg,
  output logic [ROT_W-1:0] rot_count,
  output logic             fault
);

  state_t      state;
  logic [15:0] data;
  logic [3:0]  prev_q;
  logic        rec_armed;
  logic [3:0]  digit;
  logic [6:0]  dec_seg;
  logic        transfer;
  logic        ring_ok;
  logic        step_ok;

  assign load_ready = !reset && (state != FAULT);
  assign transfer   = load_valid && load_ready;
  assign ring_ok    = is_onehot(ring_q);
  assign step_ok    = ring_ok && ((ring_q == prev_q) || (ring_q == rotl4(prev_q)));

  // Pick the stored digit that the current ring phase points at.
  always_comb begin
    digit = data[3:0];
    if (ring_q[3])      digit = data[15:12];
    else if (ring_q[2]) digit = data[11:8];
    else if (ring_q[1]) digit = data[7:4];
  end

  hex_to_seg7 u_hex_to_seg7 (
    .hex (digit),
    .seg (dec_seg)
  );

  // State machine, data capture, rotation counting and registered display outputs.
  // Recovery from FAULT needs two one-hot edges counted from inside FAULT;
  // rec_armed remembers the first of them.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      data      <= '0;
      prev_q    <= 4'b0001;
      an        <= '0;
      seg       <= '0;
      rot_count <= '0;
      fault     <= 1'b0;
      rec_armed <= 1'b0;
    end else begin
      prev_q <= ring_q;
      an     <= '0;
      seg    <= '0;
      case (state)
        IDLE: begin
          fault     <= 1'b0;
          rec_armed <= 1'b0;
          if (transfer) begin
            data      <= load_data;
            rot_count <= '0;
            state     <= SCAN;
          end
        end
        SCAN: begin
          if (transfer) begin
            data      <= load_data;
            rot_count <= '0;
          end else if ((prev_q == 4'b1000) && (ring_q == 4'b0001) && (rot_count != '1)) begin
            rot_count <= rot_count + ROT_W'(1);
          end
          if (!step_ok) begin
            state     <= FAULT;
            fault     <= 1'b1;
            rec_armed <= 1'b0;
          end else begin
            an  <= ring_q;
            seg <= dec_seg;
          end
        end
        FAULT: begin
          if (ring_ok && rec_armed) begin
            state     <= SCAN;
            fault     <= 1'b0;
            rec_armed <= 1'b0;
          end else begin
            rec_armed <= ring_ok;
          end
        end
        default: begin
          state     <= IDLE;
          fault     <= 1'b0;
          rec_armed <= 1'b0;
        end
      endcase
    end
  end

endmodule
